// File: rtl/restoring_divider_if.sv
// Operand/result bus between a divider client (master) and the sequential restoring divider (slave).
interface restoring_divider_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;
  logic         done;
  logic         busy;
  logic         div_by_zero;

  modport master (output start, output data_in,
                  input data_out, input done, input busy, input div_by_zero);
  modport slave  (input start, input data_in,
                  output data_out, output done, output busy, output div_by_zero);
endinterface

// File: rtl/restoring_divider.sv
// Sequential N-bit unsigned restoring divider; 3N+5..4N+5 cycles Init1..Exp2 (5 on divide-by-zero).
// No backpressure: start is only sampled in Idle, results are presented for exactly two done cycles.
module restoring_divider #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  restoring_divider_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT1   = 4'd1,
    INIT2   = 4'd2,
    CHECK   = 4'd3,
    SHIFT   = 4'd4,
    SUB     = 4'd5,
    TEST    = 4'd6,
    RESTORE = 4'd7,
    EXP1    = 4'd8,
    EXP2    = 4'd9
  } state_t;

  state_t        state;
  state_t        nextState;
  logic [N:0]    regA;
  logic [N-1:0]  regQ;
  logic [N-1:0]  regM;
  logic [CW-1:0] cnt;
  logic          dz;
  logic          lastIter;

  assign lastIter = (cnt == CW'(N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = bus.start ? INIT1 : IDLE;
      INIT1:   nextState = INIT2;
      INIT2:   nextState = CHECK;
      CHECK:   nextState = (regM == '0) ? EXP1 : SHIFT;
      SHIFT:   nextState = SUB;
      SUB:     nextState = TEST;
      // A[N] set means the trial subtraction went negative
      TEST:    nextState = regA[N] ? RESTORE : (lastIter ? EXP1 : SHIFT);
      RESTORE: nextState = lastIter ? EXP1 : SHIFT;
      EXP1:    nextState = EXP2;
      EXP2:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.done        = 1'b0;
    bus.busy        = (state != IDLE);
    bus.div_by_zero = 1'b0;
    bus.data_out    = '0;
    if (state == EXP1) begin
      bus.done        = 1'b1;
      bus.div_by_zero = dz;
      bus.data_out    = regQ;
    end else if (state == EXP2) begin
      bus.done        = 1'b1;
      bus.div_by_zero = dz;
      bus.data_out    = regA[N-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regA <= '0;
      regQ <= '0;
      regM <= '0;
      cnt  <= '0;
      dz   <= 1'b0;
    end else begin
      case (state)
        INIT1: begin
          regQ <= bus.data_in;
          regA <= '0;
          cnt  <= '0;
          dz   <= 1'b0;
        end
        INIT2: regM <= bus.data_in;
        // Divide by zero reports quotient all-ones and remainder = dividend
        CHECK: if (regM == '0) begin
          dz   <= 1'b1;
          regA <= {1'b0, regQ};
          regQ <= '1;
        end
        SHIFT: begin
          {regA, regQ} <= {regA[N-1:0], regQ, 1'b0};
          cnt          <= cnt + 1'b1;
        end
        SUB:     regA <= regA - {1'b0, regM};
        TEST:    if (!regA[N]) regQ[0] <= 1'b1;
        RESTORE: regA <= regA + {1'b0, regM};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed scenarios plus random operands against an arithmetic model.
module tb_restoring_divider;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  restoring_divider_if #(.N(N)) bus();
  restoring_divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz0;
    logic         dz1;
    int           cycles;
    int           doneCnt;
    int           doneAt;
    int           lag;
    bit           leak;
  } res_t;

  // Quotient/remainder from plain arithmetic; each zero quotient bit costs one restore cycle.
  function automatic void refDiv(input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] q, output logic [N-1:0] r, output int cyc);
    if (b == '0) begin
      q = '1;
      r = a;
      cyc = 5;
    end else begin
      q = a / b;
      r = a % b;
      cyc = 3 * N + 5 + (N - $countones(q));
    end
  endfunction

  // mode: 0 = start pulse, 1 = start held high, 2 = random start noise while busy
  task automatic runDiv(input logic [N-1:0] a, input logic [N-1:0] b, input int mode,
                        input bit chainIn, input bit chainOut, output res_t res);
    res.q = '0; res.r = '0; res.dz0 = 1'b0; res.dz1 = 1'b0;
    res.cycles = 0; res.doneCnt = 0; res.doneAt = -1; res.lag = -1; res.leak = 1'b0;
    if (!chainIn) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.data_in = '0;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0)      bus.data_in = a;
      else if (i == 1) bus.data_in = b;
      else             bus.data_in = N'($urandom);
      bus.start = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom) : 1'b0;
      if (bus.busy) begin
        if (res.lag < 0) res.lag = i;
        res.cycles++;
        if (bus.done) begin
          if (res.doneCnt == 0) begin
            res.q = bus.data_out; res.dz0 = bus.div_by_zero; res.doneAt = res.cycles;
          end else begin
            res.r = bus.data_out; res.dz1 = bus.div_by_zero;
          end
          res.doneCnt++;
        end else if (bus.data_out !== '0 || bus.div_by_zero !== 1'b0) res.leak = 1'b1;
      end else begin
        if (bus.done !== 1'b0 || bus.data_out !== '0) res.leak = 1'b1;
        if (res.cycles > 0) break;
      end
    end
    bus.start = chainOut;
  endtask

  task automatic test_reset();
    res_t res;
    bit sawDone = 1'b0;
    bit sawBusy = 1'b0;
    rst = 1'b0; bus.start = 1'b0; bus.data_in = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b dz=%b data_out=%0d, required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.data_out);
    end
    rst = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.data_in = 8'd100;
    @(negedge clk); bus.data_in = 8'd7;
    repeat (11) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: busy=%b required 1", bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL abort_async_outputs: busy=%b done=%b dz=%b data_out=%0d, required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.data_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
      if (bus.busy) sawBusy = 1'b1;
    end
    checks++;
    if (sawDone) begin errors++; $display("FAIL abort_no_done: done seen=1 required 0"); end
    checks++;
    if (sawBusy) begin errors++; $display("FAIL abort_idle: busy seen=1 required 0"); end
    runDiv(8'd100, 8'd7, 0, 1'b0, 1'b0, res);
    checks++;
    if (res.q !== 8'd14 || res.r !== 8'd2) begin
      errors++;
      $display("FAIL after_abort: q=%0d r=%0d required q=14 r=2", res.q, res.r);
    end
  endtask

  task automatic test_basic();
    res_t res;
    runDiv(8'd100, 8'd7, 0, 1'b0, 1'b0, res);
    checks++;
    if (res.q !== 8'd14) begin errors++; $display("FAIL basic_q: got %0d required 14", res.q); end
    checks++;
    if (res.r !== 8'd2) begin errors++; $display("FAIL basic_r: got %0d required 2", res.r); end
    checks++;
    if (res.dz0 !== 1'b0 || res.dz1 !== 1'b0) begin
      errors++; $display("FAIL basic_dz: got %b%b required 00", res.dz0, res.dz1);
    end
    checks++;
    if (res.doneCnt != 2 || res.doneAt != res.cycles - 1) begin
      errors++;
      $display("FAIL basic_done_len: done cycles=%0d at %0d of %0d, required 2 ending at last", res.doneCnt, res.doneAt, res.cycles);
    end
    checks++;
    if (res.leak) begin errors++; $display("FAIL basic_idle_zero: data_out/done nonzero outside done, required 0"); end
  endtask

  task automatic test_latency();
    logic [N-1:0] as [2] = '{8'd255, 8'd5};
    logic [N-1:0] bs [2] = '{8'd1, 8'd7};
    int           cs [2] = '{29, 37};
    logic [N-1:0] eq, er;
    int           ec;
    res_t res;
    for (int i = 0; i < 2; i++) begin
      refDiv(as[i], bs[i], eq, er, ec);
      runDiv(as[i], bs[i], 0, 1'b0, 1'b0, res);
      checks++;
      if (res.q !== eq || res.r !== er) begin
        errors++;
        $display("FAIL latency_result %0d/%0d: q=%0d r=%0d required q=%0d r=%0d", as[i], bs[i], res.q, res.r, eq, er);
      end
      checks++;
      if (res.cycles != cs[i]) begin
        errors++;
        $display("FAIL latency_cycles %0d/%0d: got %0d required %0d", as[i], bs[i], res.cycles, cs[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [N-1:0] as [2] = '{8'd0, 8'd37};
    logic [N-1:0] eq, er;
    int           ec;
    res_t res;
    for (int i = 0; i < 2; i++) begin
      refDiv(as[i], 8'd0, eq, er, ec);
      runDiv(as[i], 8'd0, 0, 1'b0, 1'b0, res);
      checks++;
      if (res.q !== eq || res.r !== er) begin
        errors++;
        $display("FAIL dz_result %0d/0: q=%0d r=%0d required q=%0d r=%0d", as[i], res.q, res.r, eq, er);
      end
      checks++;
      if (res.dz0 !== 1'b1 || res.dz1 !== 1'b1) begin
        errors++; $display("FAIL dz_flag %0d/0: got %b%b required 11", as[i], res.dz0, res.dz1);
      end
      checks++;
      if (res.cycles != ec || res.doneAt != 4) begin
        errors++;
        $display("FAIL dz_timing %0d/0: cycles=%0d exp1_at=%0d required cycles=%0d exp1_at=4", as[i], res.cycles, res.doneAt, ec);
      end
    end
  endtask

  task automatic test_handshake();
    logic [N-1:0] a, b, eq, er;
    int           ec;
    res_t res;
    runDiv(8'd200, 8'd13, 1, 1'b0, 1'b0, res);
    checks++;
    if (res.q !== 8'd15 || res.r !== 8'd5) begin
      errors++; $display("FAIL hold_start: q=%0d r=%0d required q=15 r=5", res.q, res.r);
    end
    for (int i = 0; i < 4; i++) begin
      a = N'($urandom);
      b = N'($urandom_range(255, 1));
      refDiv(a, b, eq, er, ec);
      runDiv(a, b, 2, 1'b0, 1'b0, res);
      checks++;
      if (res.q !== eq || res.r !== er || res.cycles != ec) begin
        errors++;
        $display("FAIL start_noise %0d/%0d: q=%0d r=%0d cyc=%0d required q=%0d r=%0d cyc=%0d",
                 a, b, res.q, res.r, res.cycles, eq, er, ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] eq, er;
    int           ec;
    res_t res;
    runDiv(8'd91, 8'd9, 0, 1'b0, 1'b1, res);
    checks++;
    if (res.q !== 8'd10 || res.r !== 8'd1) begin
      errors++; $display("FAIL b2b_first: q=%0d r=%0d required q=10 r=1", res.q, res.r);
    end
    refDiv(8'd250, 8'd3, eq, er, ec);
    runDiv(8'd250, 8'd3, 0, 1'b1, 1'b0, res);
    checks++;
    if (res.lag != 0) begin errors++; $display("FAIL b2b_start: Init1 offset=%0d required 0", res.lag); end
    checks++;
    if (res.q !== eq || res.r !== er || res.cycles != ec) begin
      errors++;
      $display("FAIL b2b_second: q=%0d r=%0d cyc=%0d required q=%0d r=%0d cyc=%0d", res.q, res.r, res.cycles, eq, er, ec);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, eq, er;
    int           ec;
    res_t res;
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom);
      b = N'($urandom_range(255, 1));
      refDiv(a, b, eq, er, ec);
      runDiv(a, b, 0, 1'b0, 1'b0, res);
      checks++;
      if (res.q !== eq) begin errors++; $display("FAIL rand_q %0d/%0d: got %0d required %0d", a, b, res.q, eq); end
      checks++;
      if (res.r !== er) begin errors++; $display("FAIL rand_r %0d/%0d: got %0d required %0d", a, b, res.r, er); end
      checks++;
      if (res.dz0 !== 1'b0 || res.dz1 !== 1'b0) begin
        errors++; $display("FAIL rand_dz %0d/%0d: got %b%b required 00", a, b, res.dz0, res.dz1);
      end
      checks++;
      if (res.cycles != ec || res.lag != 0) begin
        errors++;
        $display("FAIL rand_busy %0d/%0d: busy cycles=%0d offset=%0d required %0d and 0", a, b, res.cycles, res.lag, ec);
      end
      checks++;
      if (res.doneCnt != 2 || res.doneAt != ec - 1 || res.leak) begin
        errors++;
        $display("FAIL rand_done %0d/%0d: done cycles=%0d at %0d leak=%0d required 2 at %0d leak=0",
                 a, b, res.doneCnt, res.doneAt, res.leak, ec - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_div_by_zero();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential N-bit unsigned restoring divider: the inverse operation to the team's sequential Booth multiplier. It has a matching controller and handshake style: start pulse, operands loaded on a shared bus in consecutive cycles, and results returned over two `done` cycles (quotient, then remainder). It contains its own FSM and datapath: remainder register A (N+1 bits), quotient/dividend register Q, divisor register M and an iteration counter.

## Interface
- `N`, 8, operand/result width (N ≥ 2).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a division; sampled only in Idle.
- `data_in`  in  N  operand bus: dividend during Init1, divisor during Init2.
- `data_out`  out  N  quotient in Exp1, remainder in Exp2, 0 otherwise.
- `done`  out  1  high in Exp1 and Exp2 only.
- `busy`  out  1  high in every state except Idle.
- `div_by_zero`  out  1  high in Exp1/Exp2 when the latched divisor was 0.

## Operation
- States: Idle, Init1, Init2, Check, Shift, Sub, Test, Restore, Exp1, Exp2. The state register is 4 bits; unused encodings go to Idle.
- Idle:
  - start=1 → Init1; otherwise stay in Idle.
  - start is ignored in all other states.
- Init1: Q←data_in, A←0, cnt←0, dz←0. → Init2.
- Init2: M←data_in. → Check.
- Check:
  - M==0 → Exp1, with dz←1, A←{0,Q} (remainder = dividend), Q←all-ones.
  - Otherwise → Shift.
- Shift: {A,Q}←{A,Q}<<1, Q[0]←0, cnt←cnt+1. → Sub.
- Sub: A←A−M, computed mod 2^(N+1). → Test.
- Test:
  - If A[N]=1 (negative) → Restore.
  - Else Q[0]←1, then → Exp1 if cnt==N, else → Shift.
- Restore: A←A+M, Q[0] stays 0. → Exp1 if cnt==N, else → Shift.
- Exp1: done=1, data_out=Q (quotient), div_by_zero=dz. → Exp2.
- Exp2: done=1, data_out=A[N−1:0] (remainder), div_by_zero=dz. → Idle.
- Arithmetic widths:
  - A is N+1 bits; after Test/Restore, A[N]=0 and A<M.
  - cnt is ⌈log2(N+1)⌉ bits.
- Outputs are decoded from the present state only (Moore).
- Results are defined only for unsigned operands.

## Timing
- Reset value of every register and output is 0: state=Idle, A, Q, M, cnt, dz; done=busy=div_by_zero=0, data_out=0.
- Reset asserted mid-operation aborts at once and returns to Idle. No done is produced for the aborted division.
- Operand timing:
  - start is sampled at edge k.
  - Dividend must be valid on data_in during the cycle after k (Init1).
  - Divisor must be valid during the following cycle (Init2).
- Each iteration takes 3 cycles (Shift, Sub, Test) with no restore, or 4 cycles (+Restore) with a restore.
- Latency, counted in cycles from Init1 through Exp2 inclusive: 3 + Σ(iteration cycles) + 2.
  - Best case: 3N+5 (29 for N=8).
  - Worst case: 4N+5 (37 for N=8).
- Divide-by-zero: Init1, Init2, Check, Exp1, Exp2 = 5 cycles.
- Back-to-back operation: start may be asserted in the Idle cycle directly after Exp2. The earliest new Init1 is 1 cycle after Exp2.
- data_out is 0 whenever done=0.

## Test plan
- Reset: apply reset, then assert rst async mid-clock → all outputs 0, state Idle. Start 100/7, assert rst during Sub of iteration 3 → back to Idle. No done; the next division 100/7 completes correctly.
- Basic: N=8, 100/7 → Exp1 data_out=14, Exp2 data_out=2, div_by_zero=0, done high exactly 2 cycles.
- Latency extremes:
  - 255/1 → q=255, r=0, 29 cycles Init1..Exp2, no Restore visits.
  - 5/7 → q=0, r=5, 37 cycles, 8 Restore visits.
- Divide by zero: 0/0 → Exp1 data_out=255, Exp2 data_out=0, div_by_zero=1 both cycles, Exp1 on the 4th cycle after Init1. 37/0 → r=37.
- Handshake: start held high throughout 200/13 → q=15, r=5. A second division begins only from Idle, and start pulses during busy are ignored.
- Random: 1000 random dividend/divisor pairs (divisor≠0) checked against q=a/b, r=a%b, with busy high from Init1 to Exp2 inclusive.
